lsm_sequencer: RTL and testbench

//  Sequences ARM load/store-multiple (LDM/STM) transfers for the datapath control unit.

---
 rtl/lsm_pkg.sv | 33 +++
 rtl/lsm_prio_enc.sv | 23 ++
 rtl/lsm_sequencer.sv | 139 +++++++++++++
 tb/tb_lsm_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsm_pkg.sv
// Shared types and helpers for the load/store-multiple sequencer.
// Holds the state encoding, addressing-mode decode and the register-list popcount.
package lsm_pkg;

  localparam int unsigned ListW     = 16;
  localparam int unsigned WordBytes = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetup   = 3'd1,
    StReq     = 3'd2,
    StRelease = 3'd3,
    StDone    = 3'd4
  } state_e;

  // Encoded as {P,U}
  typedef enum logic [1:0] {
    ModeDA = 2'b00,
    ModeIA = 2'b01,
    ModeDB = 2'b10,
    ModeIB = 2'b11
  } mode_e;

  function automatic logic [4:0] popcount(input logic [ListW-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(ListW); i++) begin
      cnt = cnt + {4'b0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit encoder for the remaining register list.
// Index is zero when no bit is set; valid flags a non-empty vector.
module lsm_prio_enc
  import lsm_pkg::*;
(
  input  logic [ListW-1:0] vec,
  output logic [3:0]       idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set bit is the last one to win
    for (int i = int'(ListW) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM transfer sequencer: walks the register list in ascending order, drives one
// four-phase memory handshake per register and produces the base writeback value.
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LIST_W     = ListW,
  parameter int unsigned WORD_BYTES = WordBytes
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsm_en,
  input  logic [LIST_W-1:0] reg_list,
  input  logic              p_bit,
  input  logic              u_bit,
  input  logic [ADDR_W-1:0] base,
  input  logic              moc,
  output logic              lsm_detect,
  output logic              xfer_req,
  output logic [3:0]        reg_idx,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] wb_value,
  output logic              lsm_end,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] Step = ADDR_W'(WORD_BYTES);

  state_e            state_q, state_d;
  logic [LIST_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wb_q, wb_d;
  logic              p_q, p_d;
  logic              u_q, u_d;
  logic [3:0]        idx_q, idx_d;

  logic [3:0]        enc_idx;
  logic              enc_valid;
  logic [4:0]        count;
  logic [ADDR_W-1:0] span;
  mode_e             mode;

  lsm_prio_enc u_prio_enc (
    .vec   (mask_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign count = popcount(mask_q);
  assign span  = ADDR_W'(count) * Step;
  assign mode  = mode_e'({p_q, u_q});

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    base_d   = base_q;
    addr_d   = addr_q;
    wb_d     = wb_q;
    p_d      = p_q;
    u_d      = u_q;
    idx_d    = idx_q;
    xfer_req = 1'b0;
    lsm_end  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lsm_en) begin
          mask_d  = reg_list;
          base_d  = base;
          p_d     = p_bit;
          u_d     = u_bit;
          state_d = StSetup;
        end
      end
      StSetup: begin
        // Lowest register always lands on the lowest address of the block
        unique case (mode)
          ModeIA:  addr_d = base_q;
          ModeIB:  addr_d = base_q + Step;
          ModeDA:  addr_d = base_q - span + Step;
          ModeDB:  addr_d = base_q - span;
          default: addr_d = base_q;
        endcase
        wb_d    = u_q ? (base_q + span) : (base_q - span);
        state_d = enc_valid ? StReq : StDone;
      end
      StReq: begin
        xfer_req = 1'b1;
        if (moc) begin
          mask_d  = mask_q & ~(LIST_W'(1) << enc_idx);
          idx_d   = enc_idx;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!moc) begin
          addr_d  = addr_q + Step;
          state_d = (mask_q == '0) ? StDone : StReq;
        end
      end
      StDone: begin
        lsm_end = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wb_q    <= '0;
      p_q     <= 1'b0;
      u_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
      p_q     <= p_d;
      u_q     <= u_d;
      idx_q   <= idx_d;
    end
  end

  // The mask bit is already cleared in RELEASE, so hold the index of the transfer in flight
  assign reg_idx    = (state_q == StRelease) ? idx_q : enc_idx;
  assign lsm_detect = (mask_q != '0);
  assign addr       = addr_q;
  assign wb_value   = wb_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_lsm_sequencer.sv
// Self-checking bench for lsm_sequencer: table of LDM/STM runs against a
// handshaking memory model that scoreboards every (register, address) transfer.
module tb_lsm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        lsm_en;
  logic [15:0] reg_list;
  logic        p_bit;
  logic        u_bit;
  logic [31:0] base;
  logic        moc;
  logic        lsm_detect;
  logic        xfer_req;
  logic [3:0]  reg_idx;
  logic [31:0] addr;
  logic [31:0] wb_value;
  logic        lsm_end;
  logic        busy;

  lsm_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lsm_en     (lsm_en),
    .reg_list   (reg_list),
    .p_bit      (p_bit),
    .u_bit      (u_bit),
    .base       (base),
    .moc        (moc),
    .lsm_detect (lsm_detect),
    .xfer_req   (xfer_req),
    .reg_idx    (reg_idx),
    .addr       (addr),
    .wb_value   (wb_value),
    .lsm_end    (lsm_end),
    .busy       (busy)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] addr;
  } xfer_t;

  typedef struct {
    logic [31:0] base;
    logic [15:0] list;
    logic        p;
    logic        u;
    logic [31:0] first;
    logic [31:0] wb;
    int          delay;
    bit          noise;
  } vec_t;

  xfer_t exp_q[$];
  xfer_t last;
  int    total = 0;
  int    bad = 0;
  int    moc_delay = 0;
  int    wait_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: raise MOC after moc_delay extra cycles of request, drop it once the request drops
  initial begin
    moc  = 1'b0;
    last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        moc      = 1'b0;
        wait_cnt = 0;
      end else if (xfer_req && !moc) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_unexpected: idx=%0d addr=%h, no transfer expected", reg_idx, addr);
          moc = 1'b1;
        end else begin
          check("req_idx", 32'(reg_idx), 32'(exp_q[0].idx));
          check("req_addr", addr, exp_q[0].addr);
          if (wait_cnt >= moc_delay) begin
            last     = exp_q.pop_front();
            moc      = 1'b1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end else if (moc && !xfer_req) begin
        check("rel_idx", 32'(reg_idx), 32'(last.idx));
        check("rel_addr", addr, last.addr);
        moc = 1'b0;
      end
    end
  end

  task automatic start_vec(input vec_t v, output int n);
    xfer_t t;
    n = 0;
    for (int b = 0; b < 16; b++) begin
      if (v.list[b]) begin
        t.idx  = 4'(b);
        t.addr = v.first + 32'(4 * n);
        exp_q.push_back(t);
        n++;
      end
    end
    moc_delay = v.delay;
    base      = v.base;
    reg_list  = v.list;
    p_bit     = v.p;
    u_bit     = v.u;
    lsm_en    = 1'b1;
    @(negedge clk);
    lsm_en = 1'b0;
    check("busy_setup", 32'(busy), 32'd1);
    check("detect_setup", 32'(lsm_detect), 32'(v.list != 16'h0));
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int k;
    bit seen;
    start_vec(v, n);
    k    = 1;
    seen = 1'b0;
    while (!seen && k < 500) begin
      if (lsm_end) begin
        seen = 1'b1;
      end else begin
        if (v.noise) lsm_en = (k % 3 == 0);
        @(negedge clk);
        k++;
      end
    end
    lsm_en = 1'b0;
    check("end_seen", 32'(seen), 32'd1);
    check("latency", 32'(k), 32'(2 + n * (2 + v.delay)));
    check("wb_value", wb_value, v.wb);
    check("xfers_left", 32'(exp_q.size()), 32'd0);
    check("detect_done", 32'(lsm_detect), 32'd0);
    // Start request while in DONE must be ignored
    if (v.noise) lsm_en = 1'b1;
    @(negedge clk);
    lsm_en = 1'b0;
    check("end_pulse_len", 32'(lsm_end), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_req", 32'(xfer_req), 32'd0);
    check("wb_held", wb_value, v.wb);
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {27'b0, lsm_detect, xfer_req, lsm_end, busy, moc & 1'b0}, 32'd0);
    check({tag, "_idx"}, 32'(reg_idx), 32'd0);
    check({tag, "_addr"}, addr, 32'd0);
    check({tag, "_wb"}, wb_value, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vec_t rv;
    int   n;
    int   k;

    vecs[0] = '{32'h0000_0100, 16'h8005, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_010C, 0, 1'b0};
    vecs[1] = '{32'h0000_0100, 16'h000F, 1'b1, 1'b0, 32'h0000_00F0, 32'h0000_00F0, 0, 1'b0};
    vecs[2] = '{32'h0000_0040, 16'h0000, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFC, 16'h0003, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004, 0, 1'b0};
    vecs[4] = '{32'h0000_0200, 16'h0110, 1'b0, 1'b0, 32'h0000_01FC, 32'h0000_01F8, 1, 1'b0};
    vecs[5] = '{32'h0000_0000, 16'hFFFF, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0040, 0, 1'b0};
    vecs[6] = '{32'h0000_1000, 16'h0042, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_1008, 5, 1'b1};

    rst_n    = 1'b0;
    lsm_en   = 1'b0;
    reg_list = '0;
    p_bit    = 1'b0;
    u_bit    = 1'b0;
    base     = '0;
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy0", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset during the second transfer aborts without a completion pulse
    rv = '{32'h0000_0300, 16'h000F, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0310, 3, 1'b0};
    start_vec(rv, n);
    k = 0;
    while (!(xfer_req && reg_idx == 4'd1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_2nd_xfer", 32'(k < 200), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_end_in_rst", 32'(lsm_end | busy), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(busy | lsm_end), 32'd0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
